// File: rtl/eth_pkg.sv
// eth_pkg: definitions shared by the Ethernet transmit framer and any
// future receive-side FCS checker.
//   state_t      - framer FSM states
//   ETH_PREAMBLE - preamble byte (sent seven times)
//   ETH_SFD      - start-of-frame delimiter byte
//   CRC32_POLY   - reflected IEEE 802.3 polynomial
//   CRC32_INIT   - CRC register value at the start of a frame
//   crc32_byte() - advances a reflected CRC-32 by one byte, LSB first
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
    PAD  = 3'd3,
    FCS  = 3'd4,
    IFG  = 3'd5
  } state_t;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;

  // The reflected form shifts right, so bit 0 of the data byte goes first,
  // matching the order in which the bits leave on the wire.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data_byte);
    logic [31:0] c;
    c = crc ^ {24'h000000, data_byte};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// eth_crc32_byte: purely combinational one-byte step of the IEEE 802.3
// CRC-32. Usable on both transmit (FCS generation) and receive (FCS check).
//   crc_in  [31:0] - current CRC register
//   data_in [7:0]  - byte to fold in
//   crc_out [31:0] - CRC register after the byte
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  assign crc_out = crc32_byte(crc_in, data_in);

endmodule

// File: rtl/eth_tx_framer.sv
// eth_tx_framer: egress framing stage. For every frame arriving on the
// payload byte stream it emits preamble/SFD (optional), the payload with
// zero latency, zero padding up to MIN_FRAME bytes, and the 4-byte FCS,
// then holds the output idle for the inter-frame gap.
//   clk, rst     - clock, synchronous active-high reset
//   in_valid     - payload byte valid
//   in_data      - payload byte
//   in_last      - last payload byte of the frame
//   in_ready     - payload byte accepted when in_valid && in_ready
//   out_valid    - framed byte valid
//   out_data     - framed byte
//   out_sop      - first byte of the frame on the wire
//   out_last     - last FCS byte
//   out_ready    - downstream accepts when out_valid && out_ready
//   tx_busy      - framer is not idle (includes the inter-frame gap)
//   frames_sent  - completed frames, wrapping at 2^32
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_FRAME   = 60,
  parameter int IFG_CYCLES  = 12,
  parameter int PREAMBLE_EN = 1,
  parameter int LEN_W       = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_last,
  input  logic        out_ready,
  output logic        tx_busy,
  output logic [31:0] frames_sent
);

  localparam logic [LEN_W-1:0] CNT_MAX     = '1;
  localparam logic [LEN_W-1:0] MIN_FRAME_L = LEN_W'(MIN_FRAME);

  // IDLE always spends one clock recognising in_valid before the next frame
  // starts, and that clock is counted as the final gap clock. The IFG state
  // itself therefore lasts IFG_CYCLES-1 clocks, so the wire sees exactly
  // IFG_CYCLES idle clocks between back-to-back frames.
  localparam logic [7:0] IFG_LAST = 8'((IFG_CYCLES > 1) ? (IFG_CYCLES - 2) : 0);

  state_t           state, state_next;
  logic [2:0]       pre_idx;
  logic [1:0]       fcs_idx;
  logic [LEN_W-1:0] byte_cnt;
  logic [LEN_W-1:0] cnt_inc;
  logic [7:0]       ifg_cnt;
  logic [31:0]      crc;
  logic [31:0]      crc_next;
  logic [31:0]      fcs_word;
  logic [7:0]       crc_data;
  logic             out_hs;

  // The byte counter sticks at its maximum instead of wrapping so that an
  // oversize frame can never look short and trigger padding.
  assign cnt_inc  = (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + 1'b1;
  assign fcs_word = ~crc;
  assign crc_data = (state == PAD) ? 8'h00 : in_data;
  assign tx_busy  = (state != IDLE);

  eth_crc32_byte u_crc (
    .crc_in  (crc),
    .data_in (crc_data),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs and next state. PRE, PAD and FCS present a byte unconditionally
  // and only move on when it is taken, so out_valid/out_data stay put while
  // out_ready is low.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    out_sop    = 1'b0;
    out_last   = 1'b0;
    out_hs     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = (PREAMBLE_EN != 0) ? PRE : DATA;
        end
      end
      PRE: begin
        out_valid = 1'b1;
        out_data  = (pre_idx == 3'd7) ? ETH_SFD : ETH_PREAMBLE;
        out_sop   = (pre_idx == 3'd0);
        out_hs    = out_ready;
        if (out_ready && (pre_idx == 3'd7)) begin
          state_next = DATA;
        end
      end
      DATA: begin
        out_valid = in_valid;
        out_data  = in_data;
        in_ready  = out_ready;
        out_sop   = (PREAMBLE_EN == 0) && in_valid && (byte_cnt == '0);
        out_hs    = in_valid && out_ready;
        if (out_hs && in_last) begin
          state_next = (cnt_inc < MIN_FRAME_L) ? PAD : FCS;
        end
      end
      PAD: begin
        out_valid = 1'b1;
        out_data  = 8'h00;
        out_hs    = out_ready;
        if (out_ready && (cnt_inc >= MIN_FRAME_L)) begin
          state_next = FCS;
        end
      end
      FCS: begin
        out_valid = 1'b1;
        case (fcs_idx)
          2'd0:    out_data = fcs_word[7:0];
          2'd1:    out_data = fcs_word[15:8];
          2'd2:    out_data = fcs_word[23:16];
          default: out_data = fcs_word[31:24];
        endcase
        out_last = (fcs_idx == 2'd3);
        out_hs   = out_ready;
        if (out_ready && (fcs_idx == 2'd3)) begin
          state_next = (IFG_CYCLES > 1) ? IFG : IDLE;
        end
      end
      IFG: begin
        if (ifg_cnt == IFG_LAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-frame bookkeeping. Everything is re-armed when a frame starts, so a
  // reset or abandoned frame can never leak CRC or count state into the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_idx     <= 3'd0;
      fcs_idx     <= 2'd0;
      byte_cnt    <= '0;
      ifg_cnt     <= 8'd0;
      crc         <= CRC32_INIT;
      frames_sent <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pre_idx  <= 3'd0;
            fcs_idx  <= 2'd0;
            byte_cnt <= '0;
            crc      <= CRC32_INIT;
          end
        end
        PRE: begin
          if (out_hs) begin
            pre_idx <= pre_idx + 3'd1;
          end
        end
        DATA, PAD: begin
          if (out_hs) begin
            byte_cnt <= cnt_inc;
            crc      <= crc_next;
          end
        end
        FCS: begin
          if (out_hs) begin
            fcs_idx <= fcs_idx + 2'd1;
            if (fcs_idx == 2'd3) begin
              frames_sent <= frames_sent + 32'd1;
              ifg_cnt     <= 8'd0;
            end
          end
        end
        IFG: begin
          ifg_cnt <= ifg_cnt + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: self-checking bench for eth_tx_framer.
// Two instances: dut_a (no preamble, no padding) is driven from a cycle
// table; dut_b (preamble, 60-byte minimum) is driven frame by frame with a
// scoreboard of expected output bytes built from a reference CRC model.
module tb_eth_tx_framer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_ready;
  logic        sel;

  logic        a_in_ready, a_out_valid, a_out_sop, a_out_last, a_tx_busy;
  logic [7:0]  a_out_data;
  logic [31:0] a_frames_sent;
  logic        b_in_ready, b_out_valid, b_out_sop, b_out_last, b_tx_busy;
  logic [7:0]  b_out_data;
  logic [31:0] b_frames_sent;

  logic        in_ready, out_valid, out_sop, out_last, tx_busy;
  logic [7:0]  out_data;
  logic [31:0] frames_sent;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       last;
  } exp_t;

  exp_t       sb_q[$];
  int         len_q[$];
  logic [7:0] pay_q[$];

  logic       mon_en      = 1'b0;
  logic       gap_arm     = 1'b0;
  logic       have_last   = 1'b0;
  logic       rand_ready  = 1'b0;
  int         last_cyc    = 0;
  int         gap_seen    = 0;

  eth_tx_framer #(.MIN_FRAME(0), .IFG_CYCLES(12), .PREAMBLE_EN(0), .LEN_W(11)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_sop(a_out_sop), .out_last(a_out_last), .out_ready(out_ready),
    .tx_busy(a_tx_busy), .frames_sent(a_frames_sent)
  );

  eth_tx_framer #(.MIN_FRAME(60), .IFG_CYCLES(12), .PREAMBLE_EN(1), .LEN_W(11)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_sop(b_out_sop), .out_last(b_out_last), .out_ready(out_ready),
    .tx_busy(b_tx_busy), .frames_sent(b_frames_sent)
  );

  assign in_ready    = sel ? b_in_ready    : a_in_ready;
  assign out_valid   = sel ? b_out_valid   : a_out_valid;
  assign out_data    = sel ? b_out_data    : a_out_data;
  assign out_sop     = sel ? b_out_sop     : a_out_sop;
  assign out_last    = sel ? b_out_last    : a_out_last;
  assign tx_busy     = sel ? b_tx_busy     : a_tx_busy;
  assign frames_sent = sel ? b_frames_sent : a_frames_sent;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Random backpressure, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
  endtask

  function automatic logic [31:0] refCrc(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int b = 0; b < 8; b++) begin
      fb = c[0] ^ d[b];
      c  = {1'b0, c[31:1]};
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  // Expected wire image for dut_b: 7x55, D5, payload, pad to 60, ~CRC LSB first.
  task automatic buildExpected();
    logic [31:0] c;
    logic [31:0] f;
    int          n;
    int          total;
    exp_t        e;
    c = 32'hFFFFFFFF;
    total = 0;
    for (int i = 0; i < 8; i++) begin
      e.data = (i == 7) ? 8'hD5 : 8'h55;
      e.sop  = (i == 0);
      e.last = 1'b0;
      sb_q.push_back(e);
      total++;
    end
    n = 0;
    for (int i = 0; i < pay_q.size(); i++) begin
      e.data = pay_q[i]; e.sop = 1'b0; e.last = 1'b0;
      sb_q.push_back(e);
      c = refCrc(c, pay_q[i]);
      n++;
      total++;
    end
    while (n < 60) begin
      e.data = 8'h00; e.sop = 1'b0; e.last = 1'b0;
      sb_q.push_back(e);
      c = refCrc(c, 8'h00);
      n++;
      total++;
    end
    f = ~c;
    for (int k = 0; k < 4; k++) begin
      e.data = f[8*k +: 8]; e.sop = 1'b0; e.last = (k == 3);
      sb_q.push_back(e);
      total++;
    end
    len_q.push_back(total);
  endtask

  task automatic sendFrame(input bit push_exp, input bit gaps);
    int k;
    bit hs;
    if (push_exp) buildExpected();
    for (int i = 0; i < pay_q.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          applyStimulus(1'b0, 8'h00, 1'b0);
          @(posedge clk); #1;
        end
      end
      applyStimulus(1'b1, pay_q[i], (i == pay_q.size() - 1));
      k  = 0;
      hs = 1'b0;
      while (!hs && k < 2000) begin
        @(negedge clk);
        hs = in_ready;
        @(posedge clk); #1;
        k++;
      end
      if (!hs) begin
        checkOutput("in_handshake", {31'b0, hs}, 32'd1);
        break;
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic waitDrain();
    int k;
    k = 0;
    while ((sb_q.size() != 0 || tx_busy) && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("drain", {31'b0, (sb_q.size() != 0 || tx_busy)}, 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor: pops one expected byte per output handshake and
  // checks that a stalled byte is held unchanged.
  initial begin
    exp_t       e;
    logic       stall_pending;
    logic [7:0] stall_data;
    int         hs_cnt;
    stall_pending = 1'b0;
    stall_data    = 8'h00;
    hs_cnt        = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        stall_pending = 1'b0;
        hs_cnt        = 0;
        continue;
      end
      if (stall_pending)
        checkOutput("hold_stable", {23'b0, out_valid, out_data}, {23'b0, 1'b1, stall_data});
      stall_pending = out_valid && !out_ready;
      stall_data    = out_data;
      if (gap_arm && have_last && out_valid && out_sop) begin
        checkOutput("ifg_gap", 32'(cyc - last_cyc - 1), 32'd12);
        have_last = 1'b0;
        gap_seen++;
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL sb_unexpected: got byte 0x%0h, want no output", out_data);
        end else begin
          e = sb_q.pop_front();
          checkOutput("sb_byte", {22'b0, out_sop, out_last, out_data}, {22'b0, e.sop, e.last, e.data});
        end
        if (out_last) begin
          if (len_q.size() > 0) checkOutput("frame_len", 32'(hs_cnt), 32'(len_q.pop_front()));
          hs_cnt    = 0;
          last_cyc  = cyc;
          have_last = 1'b1;
        end
      end
    end
  end

  typedef struct packed {
    logic       iv;
    logic [7:0] id;
    logic       il;
    logic       ev;
    logic [7:0] ed;
    logic       es;
    logic       el;
  } vec_t;

  initial begin
    vec_t       vecs[15];
    logic [7:0] fcs_exp[4];
    logic [7:0] act_d;

    // Cycle table for dut_a on "123456789"; its CRC-32 is 0xCBF43926.
    fcs_exp[0] = 8'h26; fcs_exp[1] = 8'h39; fcs_exp[2] = 8'hF4; fcs_exp[3] = 8'hCB;
    vecs[0] = '{iv: 1'b1, id: 8'h31, il: 1'b0, ev: 1'b0, ed: 8'h00, es: 1'b0, el: 1'b0};
    for (int i = 1; i <= 9; i++) begin
      vecs[i] = '{iv: 1'b1, id: 8'(8'h30 + i), il: (i == 9), ev: 1'b1,
                  ed: 8'(8'h30 + i), es: (i == 1), el: 1'b0};
    end
    for (int k = 0; k < 4; k++) begin
      vecs[10 + k] = '{iv: 1'b0, id: 8'h00, il: 1'b0, ev: 1'b1,
                       ed: fcs_exp[k], es: 1'b0, el: (k == 3)};
    end
    vecs[14] = '{iv: 1'b0, id: 8'h00, il: 1'b0, ev: 1'b0, ed: 8'h00, es: 1'b0, el: 1'b0};

    sel       = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    doReset();

    @(negedge clk);
    checkOutput("reset_a", {a_out_valid, a_in_ready, a_out_sop, a_out_last, a_tx_busy, a_out_data, a_frames_sent[18:0]}, 32'd0);
    checkOutput("reset_b", {b_out_valid, b_in_ready, b_out_sop, b_out_last, b_tx_busy, b_out_data, b_frames_sent[18:0]}, 32'd0);
    checkOutput("reset_frames", a_frames_sent | b_frames_sent, 32'd0);
    @(posedge clk); #1;

    $display("[TB] table: no preamble, no pad, payload 123456789");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].id, vecs[i].il);
      @(negedge clk);
      act_d = vecs[i].ev ? out_data : 8'h00;
      checkOutput($sformatf("table_%0d", i), {21'b0, out_valid, out_sop, out_last, act_d},
                  {21'b0, vecs[i].ev, vecs[i].es, vecs[i].el, vecs[i].ed});
      @(posedge clk); #1;
    end
    checkOutput("frames_a", frames_sent, 32'd1);

    doReset();
    sel    = 1'b1;
    mon_en = 1'b1;

    $display("[TB] 14-byte payload with preamble and pad");
    pay_q.delete();
    for (int i = 0; i < 14; i++) pay_q.push_back(8'(8'hA0 + i));
    sendFrame(1'b1, 1'b0);
    waitDrain();
    checkOutput("frames_pad", frames_sent, 32'd1);

    $display("[TB] back-to-back 64-byte frames");
    have_last = 1'b0;
    gap_arm   = 1'b1;
    pay_q.delete();
    for (int i = 0; i < 64; i++) pay_q.push_back(8'(i * 3 + 1));
    sendFrame(1'b1, 1'b0);
    pay_q.delete();
    for (int i = 0; i < 64; i++) pay_q.push_back(8'(8'hFF - i));
    sendFrame(1'b1, 1'b0);
    waitDrain();
    gap_arm = 1'b0;
    checkOutput("ifg_gap_seen", 32'(gap_seen), 32'd1);
    checkOutput("frames_b2b", frames_sent, 32'd3);

    $display("[TB] 100-byte frame with random backpressure and input gaps");
    pay_q.delete();
    for (int i = 0; i < 100; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    rand_ready = 1'b1;
    sendFrame(1'b1, 1'b1);
    waitDrain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    checkOutput("frames_rand", frames_sent, 32'd4);

    $display("[TB] reset during padding, then a 1-byte frame");
    mon_en = 1'b0;
    pay_q.delete();
    for (int i = 0; i < 14; i++) pay_q.push_back(8'(8'h11 * (i + 1)));
    sendFrame(1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("in_pad", {29'b0, out_valid, tx_busy, (out_data == 8'h00)}, 32'd7);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset", {30'b0, out_valid, tx_busy}, 32'd0);
    checkOutput("post_reset_frames", frames_sent, 32'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    pay_q.delete();
    pay_q.push_back(8'hAB);
    sendFrame(1'b1, 1'b0);
    waitDrain();
    checkOutput("frames_after_reset", frames_sent, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_tx_framer.md
Name: eth_tx_framer

Overview:
Egress framing stage directly downstream of the dataplane rewrite output (tx_valid/tx_data/tx_last/tx_ready byte stream).
- Per frame, emits in order: preamble/SFD, the payload, zero padding up to the minimum frame length, then a CRC-32 FCS.
- Enforces an inter-frame gap between frames.
- Output is a byte-wide valid/ready stream toward the PHY-side serializer.
- Keeps a frame counter for the control plane.

Parameters:
- MIN_FRAME, 60, minimum bytes before FCS (payload plus pad); 0 disables padding.
- IFG_CYCLES, 12, idle output cycles after the last FCS byte is accepted; range 0..255.
- PREAMBLE_EN, 1, 1 = emit 7x 0x55 then 0xD5 before the payload; 0 = no preamble.
- LEN_W, 11, width of the internal byte counter.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  payload byte valid (from dataplane tx_valid)
- in_data  in  8  payload byte
- in_last  in  1  last payload byte of the frame
- in_ready  out  1  payload byte accepted when in_valid && in_ready
- out_valid  out  1  framed byte valid
- out_data  out  8  framed byte
- out_sop  out  1  first byte of the frame (first preamble byte, or first payload byte if PREAMBLE_EN=0)
- out_last  out  1  last FCS byte
- out_ready  in  1  downstream accepts when out_valid && out_ready
- tx_busy  out  1  state != IDLE
- frames_sent  out  32  count of completed frames; wraps at 2^32

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; byte counter=0; CRC=0xFFFFFFFF; frames_sent=0; IFG counter=0.
  - Outputs from the next cycle: out_valid=0, in_ready=0, out_sop=0, out_last=0, tx_busy=0, out_data=0.
  - A reset mid-frame abandons the frame. Downstream sees the frame truncated with no out_last; this is required behaviour.
- States: IDLE, PRE, DATA, PAD, FCS, IFG.
- IDLE
  - in_ready=0, out_valid=0.
  - When in_valid=1, go to PRE (PREAMBLE_EN=1) or DATA (PREAMBLE_EN=0) next cycle.
  - The payload byte is not consumed in IDLE.
- PRE
  - out_valid=1. Preamble index 0..6 outputs 0x55; index 7 outputs 0xD5. out_sop=1 at index 0.
  - The index advances only on an out handshake. After the 0xD5 handshake, go to DATA.
- DATA
  - Pass-through with zero latency: out_valid=in_valid, out_data=in_data, in_ready=out_ready.
  - out_sop=1 on the first payload byte only when PREAMBLE_EN=0.
  - On each handshake: byte counter increments, saturating at 2^LEN_W-1; CRC is updated with the byte.
  - An in_valid gap produces an out_valid gap. There is no underrun error.
  - On a handshake with in_last=1:
    - counter+1 < MIN_FRAME: go to PAD.
    - otherwise: go to FCS.
- PAD
  - in_ready=0, out_valid=1, out_data=0x00.
  - Each handshake increments the counter and updates the CRC.
  - When the counter reaches MIN_FRAME, go to FCS.
- FCS
  - Output the 4 bytes of ~CRC, least-significant byte first. out_last=1 on byte 3.
  - After the byte-3 handshake: frames_sent increments; go to IFG (IFG_CYCLES>0) or IDLE.
- IFG
  - out_valid=0, in_ready=0. Count IFG_CYCLES clocks, then go to IDLE.
  - The gap is measured in clocks, independent of out_ready.
- CRC: IEEE 802.3 reflected, polynomial 0xEDB88320, init 0xFFFFFFFF, processed LSB-first per byte. Covers payload and pad only; preamble/SFD excluded. Reset to init on entry to PRE/DATA from IDLE.
- out_valid never drops while a PRE/PAD/FCS byte is waiting on out_ready. out_data is stable until the handshake.
- A 1-byte frame (first byte carries in_last) is legal: it is padded, or sent straight to FCS when MIN_FRAME<=1.
- out_ready=0 in any state: all internal counters hold.

Decomposition:
- Shared package eth_pkg:
  - state enum.
  - constants ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, CRC32_POLY=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF.
  - function crc32_byte(crc, byte) returning the next CRC.
- Sub-module eth_crc32_byte: purely combinational one-byte CRC step, reusable for RX FCS checking.

Test Plan:
- PREAMBLE_EN=0, MIN_FRAME=0, payload "123456789" (0x31..0x39), out_ready=1 -> 9 bytes passed through, then FCS 0x26,0x39,0xF4,0xCB with out_last on 0xCB; frames_sent=1.
- PREAMBLE_EN=1, MIN_FRAME=60, 14-byte payload -> 0x55 x7 then 0xD5 with out_sop on the first byte; 14 payload bytes; 46 bytes 0x00; 4 FCS bytes; 72 handshakes total.
- Two back-to-back 64-byte frames with IFG_CYCLES=12 -> exactly 12 clocks of out_valid=0 between the first frame's out_last handshake and the second frame's first byte.
- Random out_ready (50%) and in_valid gaps on a 100-byte frame -> output byte sequence and FCS identical to the out_ready=1 run; out_data stable while out_valid && !out_ready.
- rst asserted for 1 cycle in the middle of PAD -> out_valid=0 and tx_busy=0 the next cycle; frames_sent=0; the following frame is correct with a fresh CRC.
- 1-byte frame 0xAB, MIN_FRAME=60 -> 0xAB followed by 59 bytes 0x00, then the FCS of that 60-byte buffer, matching a software CRC model.
